// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 key search controller and the decrypt FSM.
// Holds the search state encoding, message length, last key and the printable-character bounds.
package rc4_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LAUNCH,
    WAIT_CORE,
    RD_ADDR,
    RD_WAIT,
    CHECK,
    NEXT_KEY,
    FOUND,
    FAIL
  } search_state_t;

  localparam int          MSG_LEN    = 32;
  localparam logic [21:0] KEY_MAX    = 22'h3FFFFF;

  // A decrypted byte is plausible plaintext when it is 'a'..'z' or a space.
  localparam logic [7:0]  CHAR_LO    = 8'd97;
  localparam logic [7:0]  CHAR_HI    = 8'd122;
  localparam logic [7:0]  CHAR_SPACE = 8'd32;

endpackage

// File: rtl/char_is_valid.sv
// Plaintext byte test: lowercase letter or space. Purely combinational, zero latency.
// No handshake; the result follows the input.
module char_is_valid (
  input  logic [7:0] ch,
  output logic       valid
);
  import rc4_pkg::*;

  assign valid = ((ch >= CHAR_LO) && (ch <= CHAR_HI)) || (ch == CHAR_SPACE);

endmodule

// File: rtl/key_search_ctrl.sv
// Brute-force key search: launches the decrypt core per key, checks each output byte (3 cycles/byte).
// Waits unboundedly on core_done; rejects a key on its first bad byte; FOUND/FAIL hold until reset.
module key_search_ctrl #(
  parameter int                   KEY_WIDTH = 22,
  parameter logic [KEY_WIDTH-1:0] KEY_MAX   = rc4_pkg::KEY_MAX,
  parameter int                   MSG_LEN   = rc4_pkg::MSG_LEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [0:2][7:0] secret_key,
  output logic            core_start,
  input  logic            core_done,
  output logic [4:0]      rd_address,
  input  logic [7:0]      rd_data,
  output logic            busy,
  output logic            found,
  output logic            fail
);
  import rc4_pkg::*;

  localparam int               IDX_W    = $clog2(MSG_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

  search_state_t        state;
  logic [KEY_WIDTH-1:0] key;
  logic [IDX_W-1:0]     index;
  logic                 byte_ok;

  char_is_valid u_char_chk (
    .ch    (rd_data),
    .valid (byte_ok)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      key        <= '0;
      index      <= '0;
      secret_key <= '0;
      rd_address <= '0;
      core_start <= 1'b0;
      busy       <= 1'b0;
      found      <= 1'b0;
      fail       <= 1'b0;
    end else begin
      core_start <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            key        <= '0;
            index      <= '0;
            secret_key <= '0;
            busy       <= 1'b1;
            core_start <= 1'b1;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          state <= WAIT_CORE;
        end
        WAIT_CORE: begin
          if (core_done) begin
            index <= '0;
            state <= RD_ADDR;
          end
        end
        RD_ADDR: begin
          rd_address <= 5'(index);
          state      <= RD_WAIT;
        end
        // The RAM registers the address on this edge; q is sampled in CHECK.
        RD_WAIT: begin
          state <= CHECK;
        end
        CHECK: begin
          if (!byte_ok) begin
            state <= NEXT_KEY;
          end else if (index == LAST_IDX) begin
            busy  <= 1'b0;
            found <= 1'b1;
            state <= FOUND;
          end else begin
            index <= index + IDX_W'(1);
            state <= RD_ADDR;
          end
        end
        NEXT_KEY: begin
          if (key == KEY_MAX) begin
            busy       <= 1'b0;
            fail       <= 1'b1;
            secret_key <= 24'(KEY_MAX);
            state      <= FAIL;
          end else begin
            key        <= key + KEY_WIDTH'(1);
            secret_key <= 24'(key + KEY_WIDTH'(1));
            core_start <= 1'b1;
            state      <= LAUNCH;
          end
        end
        FOUND, FAIL: begin
          state <= state;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_search_ctrl.sv
// Randomized scoreboard bench for key_search_ctrl with behavioural decrypt-core and RAM models.
// The search is shrunk to keys 0..3 so exhaustion is reachable.
module tb_key_search_ctrl;

  localparam logic [21:0] TB_KEY_MAX = 22'd3;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [0:2][7:0] secret_key;
  logic            core_start;
  logic            core_done = 1'b0;
  logic [4:0]      rd_address;
  logic [7:0]      rd_data = 8'd0;
  logic            busy, found, fail;
  logic [7:0]      cv_in;
  logic            cv_out;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Decrypted message the core would produce for each key.
  logic [7:0] img [4][32];

  typedef struct {
    int kind;   // 0 = core_start pulse, 1 = found, 2 = fail
    int key;
    int reads;  // bytes read since the previous core_done, -1 = untimed
  } ev_t;
  ev_t sb[$];

  key_search_ctrl #(
    .KEY_WIDTH (22),
    .KEY_MAX   (TB_KEY_MAX),
    .MSG_LEN   (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .secret_key (secret_key),
    .core_start (core_start),
    .core_done  (core_done),
    .rd_address (rd_address),
    .rd_data    (rd_data),
    .busy       (busy),
    .found      (found),
    .fail       (fail)
  );

  char_is_valid u_cv (
    .ch    (cv_in),
    .valid (cv_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Decrypt core: done drops when started and rises 5 cycles after the start pulse.
  int core_cnt = 0;
  always @(posedge clk) begin
    if (core_start) begin
      core_done <= 1'b0;
      core_cnt  <= 4;
    end else if (core_cnt > 1) begin
      core_cnt <= core_cnt - 1;
    end else if (core_cnt == 1) begin
      core_done <= 1'b1;
      core_cnt  <= 0;
    end
  end

  always @(posedge clk) rd_data <= img[secret_key[2][1:0]][rd_address];

  function automatic bit is_text(input logic [7:0] b);
    return ((b >= "a") && (b <= "z")) || (b == " ");
  endfunction

  function automatic logic [7:0] rand_text();
    int r = $urandom_range(0, 26);
    return (r == 26) ? " " : 8'("a" + r);
  endfunction

  function automatic logic [7:0] rand_bad();
    logic [7:0] b;
    do b = 8'($urandom_range(0, 255)); while (is_text(b));
    return b;
  endfunction

  task automatic fill_text();
    string s = "attack at dawn and hold the gate";
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 32; i++) img[k][i] = s[i];
  endtask

  task automatic fill_random();
    for (int k = 0; k < 4; k++) begin
      int pos = $urandom_range(0, 40);
      for (int i = 0; i < 32; i++) img[k][i] = rand_text();
      if (pos < 32) img[k][pos] = rand_bad();
    end
  endtask

  // Reference: try keys in order, stop at the first key whose message is all text.
  task automatic expect_search();
    int prev = -1;
    for (int k = 0; k <= int'(TB_KEY_MAX); k++) begin
      int n = 0;
      bit bad = 0;
      sb.push_back('{0, k, prev});
      for (int i = 0; i < 32 && !bad; i++) begin
        n = i + 1;
        if (!is_text(img[k][i])) bad = 1;
      end
      if (!bad) begin
        sb.push_back('{1, k, 32});
        return;
      end
      prev = n;
    end
    sb.push_back('{2, int'(TB_KEY_MAX), prev});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Timing: core_done seen at a negedge is acted on at the next posedge, then 3 cycles per byte;
  // a launch or fail needs one more cycle through NEXT_KEY.
  task automatic check_ev(input int kind, input int dcyc);
    ev_t e;
    int  act_d, exp_d;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_event: kind=%0d key=%0d, required no event", kind, int'(secret_key));
      return;
    end
    e = sb.pop_front();
    if (e.kind != kind || int'(secret_key) != e.key) begin
      miscompares++;
      $display("FAIL event: kind=%0d key=%0d, required kind=%0d key=%0d",
               kind, int'(secret_key), e.kind, e.key);
    end
    if (e.reads >= 0) begin
      vectors++;
      act_d = (dcyc < 0) ? -1 : cyc - dcyc;
      exp_d = 3 * e.reads + ((kind == 1) ? 1 : 2);
      if (act_d != exp_d) begin
        miscompares++;
        $display("FAIL event_timing: key=%0d kind=%0d delay=%0d, required %0d",
                 e.key, kind, act_d, exp_d);
      end
    end
    if (kind != 0) begin
      vectors++;
      if (busy || (found && fail)) begin
        miscompares++;
        $display("FAIL final_flags: busy=%0b found=%0b fail=%0b, required busy=0 and one flag",
                 busy, found, fail);
      end
    end
  endtask

  task automatic monitor();
    int   done_cyc = -1;
    logic prev_cs = 0, prev_fd = 0, prev_fl = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        done_cyc = -1;
        prev_cs  = 0;
        prev_fd  = 0;
        prev_fl  = 0;
      end else begin
        if (core_start) begin
          vectors++;
          if (prev_cs || !busy) begin
            miscompares++;
            $display("FAIL core_start_pulse: prev=%0b busy=%0b, required prev=0 busy=1", prev_cs, busy);
          end
          check_ev(0, done_cyc);
          done_cyc = -1;
        end else if (core_done && done_cyc < 0) begin
          done_cyc = cyc;
        end
        if (found && !prev_fd) check_ev(1, done_cyc);
        if (fail && !prev_fl) check_ev(2, done_cyc);
        prev_cs = core_start;
        prev_fd = found;
        prev_fl = fail;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (sb.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s_timeout: %0d events pending, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic run_search(input string name);
    expect_search();
    pulse_start();
    wait_drain(name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    reset = 1'b1;
    start = 1'b0;
    cv_in = 8'd0;
    fork
      monitor();
    join_none

    for (int b = 0; b < 256; b++) begin
      cv_in = 8'(b);
      #1;
      check($sformatf("char_valid_%0d", b), 32'(cv_out), 32'(is_text(8'(b))));
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_found", 32'(found), 0);
    check("rst_fail", 32'(fail), 0);
    check("rst_core_start", 32'(core_start), 0);
    check("rst_secret_key", 32'(secret_key), 0);
    check("rst_rd_address", 32'(rd_address), 0);
    @(posedge clk); #1 reset = 1'b0;

    // Key 0 decrypts to text.
    fill_text();
    run_search("key0_found");
    check("key0_found_flag", 32'(found), 1);

    // Key 0 rejected on its first byte, key 1 accepted.
    do_reset();
    fill_text();
    img[0][0] = 8'h41;
    run_search("reject_accept");

    // Every key fails on the last byte: exhaustion.
    do_reset();
    fill_text();
    for (int k = 0; k < 4; k++) img[k][31] = 8'd123;
    run_search("exhaust");
    check("exhaust_fail_flag", 32'(fail), 1);
    check("exhaust_key", 32'(secret_key), 3);

    // Characters just outside and on the edges of the accepted range.
    do_reset();
    fill_text();
    img[0][0] = 8'd96;
    img[1][0] = 8'd97; img[1][1] = 8'd122; img[1][2] = 8'd32; img[1][3] = 8'd123;
    img[2][0] = 8'd97; img[2][1] = 8'd122; img[2][2] = 8'd32;
    run_search("boundary");
    check("boundary_key", 32'(secret_key), 2);

    for (int r = 0; r < 10; r++) begin
      do_reset();
      fill_random();
      run_search($sformatf("random_%0d", r));
    end

    // Reset while reading on key 2, then restart from key 0.
    do_reset();
    fill_text();
    img[0][0] = 8'd65;
    img[1][0] = 8'd33;
    expect_search();
    pulse_start();
    t = 0;
    while (!(core_start && secret_key == 24'd2) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    while (!core_done && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("rdwait_reached", 32'(t < 1000), 1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_found", 32'(found), 0);
    check("midrst_fail", 32'(fail), 0);
    check("midrst_core_start", 32'(core_start), 0);
    check("midrst_secret_key", 32'(secret_key), 0);
    check("midrst_rd_address", 32'(rd_address), 0);
    sb.delete();
    @(posedge clk); #1 reset = 1'b0;
    run_search("restart");

    // start held for 10 cycles, then pulsed again while FOUND.
    do_reset();
    fill_text();
    img[0][0] = 8'd0;
    expect_search();
    start = 1'b1;
    repeat (10) @(posedge clk);
    #1 start = 1'b0;
    wait_drain("start_held");
    pulse_start();
    repeat (60) @(posedge clk);
    @(negedge clk);
    check("found_sticky", 32'(found), 1);
    check("found_key", 32'(secret_key), 1);
    check("found_busy", 32'(busy), 0);

    // Reset and start on the same edge: start is lost.
    @(posedge clk); #1;
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("rst_start_busy", 32'(busy), 0);
    check("rst_start_found", 32'(found), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/key_search_ctrl.md
KEY_SEARCH_CTRL -- requirements
Module: key_search_ctrl

Interface
REQ-001 Parameter KEY_WIDTH, 22, number of searched key bits; the upper 24-KEY_WIDTH key bits SHALL be tied to 0.
REQ-002 Parameter KEY_MAX, 22'h3FFFFF, last key tried before failure.
REQ-003 Parameter MSG_LEN, 32, number of decrypted bytes checked per key.
REQ-004 clk  input  1  sole clock; all logic on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse; starts a search from key 0.
REQ-007 secret_key  output  3x8  current key: [0]=MSB byte, [2]=LSB byte; this is the decrypt core key input.
REQ-008 core_start  output  1  one-cycle pulse to the decrypt FSM (initiator side of its done handshake).
REQ-009 core_done  input  1  level from the decrypt FSM; high once the message for the current key is written.
REQ-010 rd_address  output  5  read address into the decrypted-output RAM.
REQ-011 rd_data  input  8  synchronous RAM q; valid on the 2nd posedge after rd_address changes.
REQ-012 busy, found, fail  output  1 each  search in progress, valid key held, key space exhausted.

Function
REQ-013 States SHALL be IDLE, LAUNCH, WAIT_CORE, RD_ADDR, RD_WAIT, CHECK, NEXT_KEY, FOUND, FAIL.
REQ-014 IDLE: start=1 -> key<=0, index<=0, busy<=1, next LAUNCH; start is ignored in every other state.
REQ-015 LAUNCH: core_start=1 for exactly one cycle, next WAIT_CORE.
REQ-016 WAIT_CORE: hold until core_done=1, then index<=0 -> RD_ADDR; the wait is unbounded, with no timeout.
REQ-017 RD_ADDR: rd_address<=index, next RD_WAIT; RD_WAIT lasts one cycle, next CHECK (rd_data sampled in CHECK).
REQ-018 CHECK: a byte is valid iff rd_data in 8'd97..8'd122 or rd_data==8'd32.
REQ-019 CHECK, valid byte: if index==MSG_LEN-1 -> FOUND, else index+1 -> RD_ADDR.
REQ-020 CHECK, invalid byte: go to NEXT_KEY immediately; the remaining bytes SHALL NOT be read.
REQ-021 NEXT_KEY: key==KEY_MAX -> FAIL, else key<=key+1 -> LAUNCH; the key never wraps to 0.
REQ-022 FOUND: found=1, busy=0, secret_key frozen; FAIL: fail=1, busy=0, secret_key=KEY_MAX; both states SHALL be terminal until reset.
REQ-023 Per-key check latency: 3 cycles per byte, so the all-valid path takes 3*MSG_LEN cycles from leaving WAIT_CORE to entering FOUND.
REQ-024 The index counter SHALL be $clog2(MSG_LEN) bits; the key counter SHALL be KEY_WIDTH bits, compared with == only.
REQ-025 found and fail SHALL never both be 1; busy=1 exactly in LAUNCH..NEXT_KEY.
REQ-026 All outputs SHALL be registered; there is no combinational path from rd_data or core_done to any output.

Reset
REQ-027 On reset: state=IDLE, key=0, index=0, secret_key=0, rd_address=0, core_start=0, busy=0, found=0, fail=0.
REQ-028 Reset in any state, including mid-read or with core_done high, SHALL take effect on the next edge and abandon the search.
REQ-029 A reset on the same cycle as start SHALL win; start is lost.

Structure
REQ-030 The state enum, MSG_LEN, KEY_MAX and the valid-character bounds (97, 122, 32) SHALL live in shared package rc4_pkg, which the decrypt FSM also uses.
REQ-031 The byte-validity test SHALL be one sub-module, char_is_valid (8-bit in, 1-bit out, combinational), reused by the bench's checker.

Verification
REQ-032 Key 0 correct: RAM model holds "attack at dawn..." (32 valid bytes), core_done 5 cycles after core_start -> found=1, secret_key=0, 96 cycles after core_done.
REQ-033 Reject then accept: byte 0 = 8'h41 for key 0, all-valid for key 1 -> exactly 1 read on key 0, second core_start pulse, found=1 with secret_key={0,0,1}.
REQ-034 Last-byte failure: bytes 0..30 valid, byte 31 = 8'd123 on every key, KEY_MAX overridden to 3 -> 4 core_start pulses, fail=1, secret_key={0,0,3}.
REQ-035 Boundary characters: bytes 96 and 123 rejected; bytes 97, 122 and 32 accepted.
REQ-036 Reset during RD_WAIT on key 2 -> next cycle IDLE, all outputs 0; a new start restarts at key 0.
REQ-037 start held high for 10 cycles and start pulsed while in FOUND -> only one search, core_start pulses once per key.
